conv_job_sequencer: RTL and testbench
=====================================

// Module: conv_job_sequencer
// PURPOSE
//  Job-level controller for the CONV engine and its scratch memory (banks 0..5 via sel).
//  Streams a 4x4 image from a host into bank 0, then releases the CONV engine from reset.
//  Owns the memory port while loading, hands it to CONV while it runs, then drains bank 5.
//  Returns the 8 flattened results to the host on a valid/ready stream.
// PARAMETERS
//  N_IN     16    pixels loaded per job; written to bank 0 at addresses 0..N_IN-1
//  N_OUT    8     results drained per job; read from bank 5 at addresses 0..N_OUT-1
//  SEL_IMG  3'd0  bank select for the input image
//  SEL_FLAT 3'd5  bank select for the flattened results
//  TIMEOUT  1023  max cycles in RUN before abort; counter width $clog2(TIMEOUT+1)
// PORTS
//  clk           in  1  clock
//  reset         in  1  asynchronous, active-high reset
//  start         in  1  begin a job; sampled only in IDLE
//  busy          out 1  state!=IDLE
//  done          out 1  one-cycle pulse after the last output handshake
//  error         out 1  sticky timeout flag; cleared by an accepted start
//  in_valid      in  1  host pixel valid
//  in_ready      out 1  high in LOAD
//  in_data       in  5  signed pixel, raster order
//  out_valid     out 1  high in DRAIN
//  out_ready     in  1  host accepts a result
//  out_data      out 5  result, combinational from mem_rdata
//  out_last      out 1  out_valid && out_cnt==N_OUT-1
//  conv_rst      out 1  reset to the CONV engine; registered, =(next_state!=RUN)
//  conv_busy     in  1  CONV busy
//  conv_crd, conv_cwr                in 1  CONV read / write strobes
//  conv_caddr_rd, conv_caddr_wr      in 4  CONV read / write addresses
//  conv_cdata_wr                     in 5  CONV write data
//  conv_csel                         in 3  CONV bank select
//  conv_cdata_rd out 5  =mem_rdata, always passed through
//  mem_rd, mem_wr               out 1  memory read / write strobes
//  mem_addr_rd, mem_addr_wr     out 4  memory read / write addresses
//  mem_wdata                    out 5  memory write data
//  mem_sel                      out 3  memory bank select
//  mem_rdata                    in  5  combinational read data
// BEHAVIOUR
//  Reset values: state=IDLE, conv_rst=1, busy=done=error=0, counters=0, all mem_* =0.
//  FSM
//   - IDLE -start-> LOAD; this clears error.
//   - LOAD -(in handshake && in_cnt==N_IN-1)-> RUN.
//   - RUN -(seen_busy && !conv_busy)-> DRAIN.
//   - RUN -(tmo_cnt==TIMEOUT-1)-> IDLE; sets error=1.
//   - DRAIN -(out handshake && out_last)-> IDLE; done=1 on the following cycle.
//  start outside IDLE is ignored. in_valid outside LOAD is ignored.
//  LOAD: on in_valid&&in_ready, the same cycle drives mem_wr=1, mem_sel=SEL_IMG, mem_addr_wr=in_cnt,
//   mem_wdata=in_data; then in_cnt++. in_valid gaps write nothing. mem_rd=0.
//  RUN: all mem_* are driven directly from the conv_* inputs (pure mux, no added latency).
//   seen_busy is set on the first conv_busy=1 and cleared on entry to RUN.
//   tmo_cnt counts every RUN cycle; on timeout conv_rst returns to 1 the next cycle and nothing is drained.
//  DRAIN: mem_rd=1, mem_sel=SEL_FLAT, mem_addr_rd=out_cnt, mem_wr=0. out_cnt++ only on handshake.
//   While out_ready=0, the address and out_data hold stable.
//  Outside RUN, the conv_* inputs are ignored and conv_cdata_rd still mirrors mem_rdata.
//  Counters do not wrap: they clear on entry to LOAD, RUN or DRAIN respectively.
//  reset mid-job (async): immediately IDLE, conv_rst=1, partial data discarded, error=0.
//  Engine restart: the CONV engine runs from its own reset release, so each job re-asserts conv_rst.
// STRUCTURE
//  Shared header conv_defs.vh:
//   - state encodings S_IDLE, S_LOAD, S_RUN, S_DRAIN.
//   - bank selects SEL_IMG=0, SEL_L0K0=1, SEL_L0K1=2, SEL_L1A=3, SEL_L1B=4, SEL_FLAT=5.
//   - DATA_W=5, ADDR_W=4.
//  One sub-module conv_mem_mux: combinational owner-select between {LOAD, RUN(conv), DRAIN, idle-zero}.
//  FSM, counters and watchdog stay in the top.
// TESTING
//  1. Full job with the real CONV engine: start, then image pixels 1..16 -> 8 outputs match the golden
//     model, out_last on the 8th, done exactly once, error=0.
//  2. in_valid high every other cycle -> bank 0 addresses 0..15 are each written exactly once, in order,
//     and RUN is entered the cycle after pixel 16.
//  3. out_ready low for 5 cycles at index 3 -> mem_addr_rd=3 and out_data are held, no skip or duplicate,
//     8 handshakes in total.
//  4. CONV stub with conv_busy stuck at 1 -> error=1 after 1023 RUN cycles, state IDLE, conv_rst=1,
//     out_valid never asserted.
//  5. start pulsed in LOAD and in RUN -> ignored, counters intact; start in IDLE after a timeout
//     -> error clears, new job completes.
//  6. reset asserted at DRAIN index 4 -> all outputs at reset values the same cycle; the next job is clean.

Source files
------------

// File: rtl/conv_job_sequencer_pkg.sv
// Shared definitions for the CONV job sequencer: widths, job sizes, FSM encodings,
// scratch-memory bank selects and the memory-port payload.
package conv_job_sequencer_pkg;

    localparam int unsigned DATA_W    = 5;
    localparam int unsigned ADDR_W    = 4;
    localparam int unsigned SEL_W     = 3;
    localparam int unsigned N_IN      = 16;
    localparam int unsigned N_OUT     = 8;
    localparam int unsigned TIMEOUT   = 1023;
    localparam int unsigned IN_CNT_W  = $clog2(N_IN);
    localparam int unsigned OUT_CNT_W = $clog2(N_OUT);
    localparam int unsigned TMO_W     = $clog2(TIMEOUT + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    typedef enum logic [SEL_W-1:0] {
        SEL_IMG  = 3'd0,
        SEL_L0K0 = 3'd1,
        SEL_L0K1 = 3'd2,
        SEL_L1A  = 3'd3,
        SEL_L1B  = 3'd4,
        SEL_FLAT = 3'd5
    } bank_sel_e;

    typedef struct packed {
        logic              rd;
        logic              wr;
        logic [ADDR_W-1:0] addr_rd;
        logic [ADDR_W-1:0] addr_wr;
        logic [DATA_W-1:0] wdata;
        logic [SEL_W-1:0]  sel;
    } mem_bus_t;

endpackage

// File: rtl/conv_job_sequencer_mem_mux.sv
// Combinational owner select for the scratch-memory port: the loader, the CONV
// engine or the drain side, with an all-zero port while idle.
module conv_job_sequencer_mem_mux
    import conv_job_sequencer_pkg::*;
(
    input  logic [1:0] owner,
    input  mem_bus_t   load_bus,
    input  mem_bus_t   conv_bus,
    input  mem_bus_t   drain_bus,
    output mem_bus_t   mem_bus
);

    always_comb begin
        mem_bus = '0;
        case (owner)
            S_LOAD:  mem_bus = load_bus;
            S_RUN:   mem_bus = conv_bus;
            S_DRAIN: mem_bus = drain_bus;
            default: mem_bus = '0;
        endcase
    end

endmodule

// File: rtl/conv_job_sequencer.sv
// Job controller for the CONV engine: loads a 4x4 image into bank 0, runs the
// engine under a watchdog, then streams the flattened results from bank 5.
module conv_job_sequencer
    import conv_job_sequencer_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              error,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              conv_rst,
    input  logic              conv_busy,
    input  logic              conv_crd,
    input  logic              conv_cwr,
    input  logic [ADDR_W-1:0] conv_caddr_rd,
    input  logic [ADDR_W-1:0] conv_caddr_wr,
    input  logic [DATA_W-1:0] conv_cdata_wr,
    input  logic [SEL_W-1:0]  conv_csel,
    output logic [DATA_W-1:0] conv_cdata_rd,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr_rd,
    output logic [ADDR_W-1:0] mem_addr_wr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [SEL_W-1:0]  mem_sel,
    input  logic [DATA_W-1:0] mem_rdata
);

    logic [1:0]           state;
    logic [1:0]           next_state;
    logic [IN_CNT_W-1:0]  in_cnt;
    logic [OUT_CNT_W-1:0] out_cnt;
    logic [TMO_W-1:0]     tmo_cnt;
    logic                 seen_busy;
    logic                 in_fire;
    logic                 out_fire;
    logic                 in_last;
    logic                 tmo_hit;
    mem_bus_t             load_bus;
    mem_bus_t             conv_bus;
    mem_bus_t             drain_bus;
    mem_bus_t             mem_bus;

    assign in_fire       = in_valid && in_ready;
    assign out_fire      = out_valid && out_ready;
    assign in_last       = (in_cnt == IN_CNT_W'(N_IN - 1));
    assign tmo_hit       = (tmo_cnt == TMO_W'(TIMEOUT - 1));
    assign out_last      = out_valid && (out_cnt == OUT_CNT_W'(N_OUT - 1));
    assign out_data      = mem_rdata;
    assign conv_cdata_rd = mem_rdata;

    // Per-owner views of the memory port
    always_comb begin
        load_bus         = '0;
        load_bus.wr      = in_fire;
        load_bus.sel     = SEL_IMG;
        load_bus.addr_wr = ADDR_W'(in_cnt);
        load_bus.wdata   = in_data;

        conv_bus.rd      = conv_crd;
        conv_bus.wr      = conv_cwr;
        conv_bus.addr_rd = conv_caddr_rd;
        conv_bus.addr_wr = conv_caddr_wr;
        conv_bus.wdata   = conv_cdata_wr;
        conv_bus.sel     = conv_csel;

        drain_bus         = '0;
        drain_bus.rd      = 1'b1;
        drain_bus.sel     = SEL_FLAT;
        drain_bus.addr_rd = ADDR_W'(out_cnt);
    end

    conv_job_sequencer_mem_mux u_mem_mux (
        .owner     (state),
        .load_bus  (load_bus),
        .conv_bus  (conv_bus),
        .drain_bus (drain_bus),
        .mem_bus   (mem_bus)
    );

    assign mem_rd      = mem_bus.rd;
    assign mem_wr      = mem_bus.wr;
    assign mem_addr_rd = mem_bus.addr_rd;
    assign mem_addr_wr = mem_bus.addr_wr;
    assign mem_wdata   = mem_bus.wdata;
    assign mem_sel     = mem_bus.sel;

    // Engine completion wins over a watchdog expiry landing on the same cycle
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (start) next_state = S_LOAD;
            S_LOAD:  if (in_fire && in_last) next_state = S_RUN;
            S_RUN: begin
                if (seen_busy && !conv_busy) next_state = S_DRAIN;
                else if (tmo_hit)            next_state = S_IDLE;
            end
            S_DRAIN: if (out_fire && out_last) next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= next_state;
    end

    // Status outputs registered from next_state so they line up with the state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            conv_rst  <= 1'b1;
            busy      <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            conv_rst  <= (next_state != S_RUN);
            busy      <= (next_state != S_IDLE);
            in_ready  <= (next_state == S_LOAD);
            out_valid <= (next_state == S_DRAIN);
            done      <= out_fire && out_last;
            if (state == S_IDLE && start)
                error <= 1'b0;
            else if (state == S_RUN && next_state == S_IDLE)
                error <= 1'b1;
        end
    end

    // Counters clear on entry to their phase and never wrap within it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_cnt    <= '0;
            out_cnt   <= '0;
            tmo_cnt   <= '0;
            seen_busy <= 1'b0;
        end else begin
            if (state != S_LOAD && next_state == S_LOAD)
                in_cnt <= '0;
            else if (in_fire && !in_last)
                in_cnt <= in_cnt + IN_CNT_W'(1);

            if (state != S_DRAIN && next_state == S_DRAIN)
                out_cnt <= '0;
            else if (out_fire && !out_last)
                out_cnt <= out_cnt + OUT_CNT_W'(1);

            if (state != S_RUN && next_state == S_RUN) begin
                tmo_cnt   <= '0;
                seen_busy <= 1'b0;
            end else if (state == S_RUN) begin
                tmo_cnt <= tmo_cnt + TMO_W'(1);
                if (conv_busy) seen_busy <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_conv_job_sequencer.sv
// Scoreboard bench for conv_job_sequencer with a scratch-memory model and a CONV stub
// that writes flat[k] = bank0[2k+1] + 1 into bank 5.
module tb_conv_job_sequencer;

    typedef struct packed { logic [3:0] addr; logic [4:0] data; } wr_exp_t;
    typedef struct packed { logic [2:0] idx; logic [4:0] data; logic last; } out_exp_t;

    logic       clk = 1'b0;
    logic       reset, start, in_valid, out_ready;
    logic [4:0] in_data;
    logic       busy, done, error, in_ready, out_valid, out_last, conv_rst;
    logic [4:0] out_data, conv_cdata_rd, mem_wdata, mem_rdata, conv_cdata_wr;
    logic       conv_busy, conv_crd, conv_cwr, mem_rd, mem_wr;
    logic [3:0] conv_caddr_rd, conv_caddr_wr, mem_addr_rd, mem_addr_wr;
    logic [2:0] conv_csel, mem_sel;

    logic [4:0] mem_model [8][16];
    logic [4:0] img_a [16];
    logic [4:0] img_b [16];
    logic [4:0] res_a [8];
    logic [4:0] res_b [8];

    wr_exp_t  load_q[$];
    out_exp_t out_q[$];

    int checks = 0, failures = 0;
    int job_hs = 0, done_count = 0, stall_at = -1, stall_left = 0;
    bit done_exp = 1'b0, saw_out_valid = 1'b0, stub_stuck = 1'b0;

    always #5 clk = ~clk;

    conv_job_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .error(error),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .conv_rst(conv_rst), .conv_busy(conv_busy), .conv_crd(conv_crd), .conv_cwr(conv_cwr),
        .conv_caddr_rd(conv_caddr_rd), .conv_caddr_wr(conv_caddr_wr),
        .conv_cdata_wr(conv_cdata_wr), .conv_csel(conv_csel), .conv_cdata_rd(conv_cdata_rd),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr_rd(mem_addr_rd), .mem_addr_wr(mem_addr_wr),
        .mem_wdata(mem_wdata), .mem_sel(mem_sel), .mem_rdata(mem_rdata)
    );

    assign mem_rdata = mem_model[mem_sel][mem_addr_rd];

    always @(posedge clk) begin
        if (mem_wr) mem_model[mem_sel][mem_addr_wr] <= mem_wdata;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Bank-0 write monitor
    initial begin
        wr_exp_t e;
        forever begin
            @(posedge clk);
            if (mem_wr === 1'b1 && mem_sel === 3'd0) begin
                if (load_q.size() == 0) begin
                    check("bank0_unexpected_write_addr", 32'(mem_addr_wr), 32'hffff_ffff);
                end else begin
                    e = load_q.pop_front();
                    check("bank0_addr", 32'(mem_addr_wr), 32'(e.addr));
                    check("bank0_data", 32'(mem_wdata), 32'(e.data));
                end
            end
        end
    end

    // Output stream and done-pulse monitor
    initial begin
        out_exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                done_exp = 1'b0;
            end else begin
                if (done || done_exp) check("done_pulse", 32'(done), 32'(done_exp));
                if (done) done_count++;
                if (out_valid) saw_out_valid = 1'b1;
                if (out_valid && !out_ready && out_q.size() > 0) begin
                    check("hold_addr", 32'(mem_addr_rd), 32'(out_q[0].idx));
                    check("hold_data", 32'(out_data), 32'(out_q[0].data));
                end
                done_exp = 1'b0;
                if (out_valid && out_ready) begin
                    if (out_q.size() == 0) begin
                        check("unexpected_output_data", 32'(out_data), 32'hffff_ffff);
                    end else begin
                        e = out_q.pop_front();
                        check("out_data", 32'(out_data), 32'(e.data));
                        check("out_last", 32'(out_last), 32'(e.last));
                        check("out_addr", 32'(mem_addr_rd), 32'(e.idx));
                    end
                    job_hs++;
                    done_exp = out_last;
                end
            end
        end
    end

    // Host output-side ready, with an optional stall at a given result index
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (stall_left > 0 && job_hs == stall_at && out_valid) begin
                out_ready = 1'b0;
                stall_left--;
            end else begin
                out_ready = 1'b1;
            end
        end
    end

    // CONV engine stub
    initial begin
        logic [4:0] rd;
        conv_busy = 0; conv_crd = 0; conv_cwr = 0; conv_csel = 0;
        conv_caddr_rd = 0; conv_caddr_wr = 0; conv_cdata_wr = 0;
        forever begin
            @(posedge clk); #1;
            if (!reset && conv_rst === 1'b0) begin
                conv_busy = 1'b1;
                if (!stub_stuck) begin
                    for (int k = 0; k < 8; k++) begin
                        conv_crd = 1'b1; conv_csel = 3'd0; conv_caddr_rd = 4'(2 * k + 1);
                        @(negedge clk);
                        rd = conv_cdata_rd;
                        @(posedge clk); #1;
                        conv_crd = 1'b0; conv_cwr = 1'b1; conv_csel = 3'd5;
                        conv_caddr_wr = 4'(k); conv_cdata_wr = rd + 5'd1;
                        @(posedge clk); #1;
                        conv_cwr = 1'b0;
                    end
                    conv_busy = 1'b0;
                    conv_csel = 3'd0;
                end
                while (conv_rst === 1'b0) begin @(posedge clk); #1; end
                conv_busy = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual=stuck required=finish");
        $fatal(1, "bench time limit");
    end

    task automatic push_expected(input logic [4:0] res [8]);
        for (int k = 0; k < 8; k++) out_q.push_back('{idx: 3'(k), data: res[k], last: (k == 7)});
    endtask

    task automatic start_job();
        job_hs = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
        check("in_ready_after_start", 32'(in_ready), 32'd1);
        check("error_after_start", 32'(error), 32'd0);
    endtask

    task automatic load_image(input logic [4:0] px [16], input bit gap, input int start_pulse_at);
        for (int i = 0; i < 16; i++) begin
            load_q.push_back('{addr: 4'(i), data: px[i]});
            in_valid = 1'b1; in_data = px[i]; start = (i == start_pulse_at);
            @(posedge clk); #1;
            in_valid = 1'b0; start = 1'b0;
            if (gap && i < 15) begin
                in_data = 5'h1f;
                @(posedge clk); #1;
            end
        end
        check("run_entry_conv_rst", 32'(conv_rst), 32'd0);
        check("run_entry_in_ready", 32'(in_ready), 32'd0);
        check("load_all_written", 32'(load_q.size()), 32'd0);
    endtask

    task automatic finish_job(input int exp_done_count);
        int n = 0;
        while (done !== 1'b1 && n < 300) begin @(posedge clk); #1; n++; end
        check("job_done_seen", 32'(done), 32'd1);
        repeat (2) begin @(posedge clk); #1; end
        check("handshakes", 32'(job_hs), 32'd8);
        check("out_queue_empty", 32'(out_q.size()), 32'd0);
        check("done_count", 32'(done_count), 32'(exp_done_count));
        check("error_after_job", 32'(error), 32'd0);
        check("busy_after_job", 32'(busy), 32'd0);
    endtask

    task automatic check_reset_values();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_conv_rst", 32'(conv_rst), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_mem_ctl", 32'({mem_rd, mem_wr, mem_sel}), 32'd0);
        check("rst_mem_addr", 32'({mem_addr_rd, mem_addr_wr, mem_wdata}), 32'd0);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 16; i++) begin
            img_a[i] = 5'(i + 1);
            img_b[i] = 5'(31 - i);
        end
        res_a = '{5'd3, 5'd5, 5'd7, 5'd9, 5'd11, 5'd13, 5'd15, 5'd17};
        res_b = '{5'd31, 5'd29, 5'd27, 5'd25, 5'd23, 5'd21, 5'd19, 5'd17};

        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 5'd0;
        #12;
        check_reset_values();
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // Full job, pixels 1..16
        push_expected(res_a);
        start_job();
        load_image(img_a, 1'b0, -1);
        finish_job(1);

        // Gapped input and a 5-cycle output stall at index 3
        stall_at = 3; stall_left = 5;
        push_expected(res_b);
        start_job();
        load_image(img_b, 1'b1, -1);
        finish_job(2);
        check("stall_consumed", 32'(stall_left), 32'd0);
        stall_at = -1;

        // Engine stuck busy: watchdog abort after 1023 RUN cycles
        stub_stuck = 1'b1; saw_out_valid = 1'b0;
        start_job();
        load_image(img_a, 1'b0, -1);
        n = 1;
        for (int c = 0; c < 1100; c++) begin
            @(posedge clk); #1;
            if (conv_rst !== 1'b0) break;
            n++;
        end
        check("run_cycles_before_abort", 32'(n), 32'd1023);
        check("abort_error", 32'(error), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_conv_rst", 32'(conv_rst), 32'd1);
        check("abort_no_out_valid", 32'(saw_out_valid), 32'd0);
        stub_stuck = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        check("error_sticky", 32'(error), 32'd1);

        // Restart after timeout, with start pulses in LOAD and RUN and a stray in_valid in RUN
        push_expected(res_a);
        start_job();
        load_image(img_a, 1'b0, 5);
        repeat (2) begin @(posedge clk); #1; end
        start = 1'b1; in_valid = 1'b1; in_data = 5'd9;
        @(posedge clk); #1;
        start = 1'b0; in_valid = 1'b0;
        check("run_ignores_start_busy", 32'(busy), 32'd1);
        check("run_ignores_start_conv_rst", 32'(conv_rst), 32'd0);
        finish_job(3);

        // Asynchronous reset in the middle of the drain
        push_expected(res_b);
        start_job();
        load_image(img_b, 1'b0, -1);
        n = 0;
        while (job_hs != 4 && n < 300) begin @(posedge clk); #1; n++; end
        check("drain_index_before_reset", 32'(mem_addr_rd), 32'd4);
        reset = 1'b1;
        #1;
        check_reset_values();
        out_q.delete();
        repeat (2) begin @(posedge clk); #1; end
        reset = 1'b0;
        @(posedge clk); #1;
        check("done_count_after_reset", 32'(done_count), 32'd3);

        // Clean job after the reset
        push_expected(res_a);
        start_job();
        load_image(img_a, 1'b0, -1);
        finish_job(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
